// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg - shared UART byte width and TX launch FSM state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_queue_if - byte ingress, transmitter launch and queue status bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_busy;
    logic [ADDR_W:0]        count;
    logic                   empty;
    logic                   full;

    // master: coprocessor/transmitter side; slave: the queue itself
    modport master (
        output in_data, in_valid, tx_busy,
        input  in_ready, tx_start, tx_data, count, empty, full
    );

    modport slave (
        input  in_data, in_valid, tx_busy,
        output in_ready, tx_start, tx_data, count, empty, full
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo - single-clock FIFO, count-based full/empty, power-of-2 DEPTH
// Revision: 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [ADDR_W:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              w_push;
    logic              w_pop;

    assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // Read is asynchronous, so a same-cycle write to this slot is not seen
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_queue - byte FIFO plus one-pulse-per-byte UART transmitter launcher
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_queue_if.slave  bus
);

    tx_state_e              state_q;
    logic                   tx_start_q;
    logic [UART_DATA_W-1:0] tx_data_q;

    logic [UART_DATA_W-1:0] w_rdata;
    logic [ADDR_W:0]        w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_launch;

    assign w_push   = bus.in_valid && !w_full;
    assign w_launch = (state_q == S_IDLE) && !w_empty && !bus.tx_busy;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_launch),
        .wdata_i (bus.in_data),
        .rdata_o (w_rdata),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // WAIT_HI guards against relaunching before the transmitter has raised busy
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_start_q <= w_launch;
                    if (w_launch) begin
                        tx_data_q <= w_rdata;
                        state_q   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    tx_start_q <= 1'b0;
                    if (bus.tx_busy) begin
                        state_q <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    tx_start_q <= 1'b0;
                    if (!bus.tx_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = !w_full;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.count    = w_count;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;

endmodule
`default_nettype wire
